// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM for the MIPS-subset CPU: sequences fetch, decode, execute, memory
// and writeback, stalls on mem_ready, times out hung accesses and counts retired instructions.
module mc_main_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             rs_eq_rt,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] instret_q;
  logic             mem_wait;
  logic             timeout;
  logic             retire;
  logic             illegal;

  assign mem_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // mem_ready on the last allowed cycle still completes the access.
  assign timeout  = mem_wait && !mem_ready && (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StDecode: begin
        unique case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StMemWr: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StAddiWb, StJump: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_q <= 8'd0;
      end else if (mem_wait && !mem_ready) begin
        wait_q <= wait_q + 8'd1;
      end
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        pc_source = 2'b01;
        pc_write  = rs_eq_rt;
      end
      StAddiWb: reg_write = 1'b1;
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal;
  assign mem_fault  = timeout;
  assign instret    = instret_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the MIPS-subset CPU.
- Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback.
- Drives datapath enables and the 2-bit alu_op into the ALU-control decoder: 00 = add, 10 = R-type (funct-decoded); 01 and 11 are never driven.
- Stalls on a memory ready handshake, times out hung accesses and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: max cycles spent in one memory state waiting for mem_ready; legal range 2..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from IR, valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- rs_eq_rt  in  1  datapath comparator, A == B
- pc_write  out  1  unconditional PC load
- ir_write  out  1  IR load
- i_or_d  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  register write data: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2
- alu_op  out  2  to ALU-control decoder
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  1-cycle pulse on an unsupported opcode
- mem_fault  out  1  1-cycle pulse on memory timeout
- instret  out  CNT_W  retired-instruction count
- state_dbg  out  4  current state encoding

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12.
- Reset (async, rst_n=0):
  - state=IDLE, instret=0, wait counter=0.
  - Every output is 0 while in IDLE.
  - IDLE advances to FETCH unconditionally on the next clock.
- Control outputs and state_dbg decode combinationally from state, mem_ready and rs_eq_rt. No unlisted output is asserted in any state.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1; that cycle transitions to DECODE. Otherwise FETCH holds.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH, nothing written.
- MEMADR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Retires, -> FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready=1; that cycle retires, -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Retires, -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=00, pc_source=01.
  - pc_write = rs_eq_rt.
  - Retires, -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Retires, -> FETCH.
- JUMP: pc_write=1, pc_source=10. Retires, -> FETCH.
- Retire: instret increments by 1 on the clock edge leaving a retiring state. Wraps modulo 2^CNT_W without saturation.
- Memory timeout (FETCH, MEMRD, MEMWR):
  - Wait counter clears on entry to each of these states and increments on every cycle with mem_ready=0.
  - If the counter reaches MEM_TIMEOUT-1 with mem_ready=0: mem_fault=1 for that cycle, next state IDLE, instret unchanged, no writes.
  - mem_ready=1 on that same cycle wins: the access completes normally and no fault is raised.
- Reset asserted mid-instruction: immediate return to IDLE; any pending write enable drops asynchronously.

Test Plan:
- Reset then mem_ready tied 1 -> state_dbg 0,1,2; ir_write=1 and pc_write=1 in the FETCH cycle only; every output 0 in IDLE.
- add (opcode 000000), mem_ready=1 -> FETCH, DECODE, EXEC (alu_op=10), ALUWB (reg_write=1, reg_dst=1); instret 0->1; 4 cycles.
- lw with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read=1, i_or_d=1; MEMWB asserts reg_write=1, mem_to_reg=1; instret +1.
- beq, rs_eq_rt=0 then 1 on two runs -> BRANCH pc_write 0 then 1, pc_source=01; both retire.
- opcode 111111 -> illegal_op pulses for exactly 1 cycle in DECODE, next FETCH, no reg_write/mem_write, instret unchanged.
- sw with mem_ready held 0, MEM_TIMEOUT=16 -> mem_fault pulses on the 16th MEMWR cycle, state -> IDLE; repeat with mem_ready=1 on the 16th cycle -> no fault, retire.
